uart_loader: RTL
================

Name: uart_loader

Overview:
- Bus initiator that drives the ACIA-style UART register interface as its host: polls status, pops received bytes and pushes transmit bytes.
- Runs a small serial monitor protocol that writes and reads system memory, so a host PC can load or inspect 6502 RAM.
- Sits beside the CPU. Has a private port to the UART registers and a private port to memory. Asserts halt while a command is in progress.

Parameters:
- TIMEOUT_CYCLES, 12000000: maximum clk cycles allowed between received bytes inside a command before the command aborts.
- GUARD_CYCLES, 4: idle cycles after each UART data write before txbusy is polled again.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- uart_cs  out  1  UART chip select
- uart_we  out  1  UART write enable
- uart_addr  out  2  UART register address: 00 data, 01 status
- uart_din  out  8  byte to UART transmit
- uart_dout  in  8  UART registered read data; bit1 rx-ready, bit0 txbusy at addr 01
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_rdata  in  8  memory read data, valid the cycle after mem_re
- halt  out  1  high while a command is active, from command byte accepted to final reply written
- err  out  1  one-cycle pulse on unknown command or timeout

Behaviour:
- Reset (rst=0 at posedge) forces state IDLE and drives these values:
  - uart_cs=0, uart_we=0, uart_addr=01, uart_din=00
  - mem_addr=0000, mem_wdata=00, mem_we=0, mem_re=0
  - halt=0, err=0
  - timeout counter=0
- Reset mid-command abandons the command. No reply byte is sent.
- UART read timing: UART dout is registered and selected by uart_addr, not by uart_cs. The address presented in cycle N is sampled from uart_dout at the end of cycle N+1. uart_addr holds stable across both cycles.
- Status poll: uart_cs=0, addr=01. Sample bit1 (rx-ready) or bit0 (txbusy) one cycle later.
- Byte receive sequence:
  - RX_POLL: poll status until bit1=1.
  - RX_POP: uart_cs=1, we=0, addr=00 for exactly one cycle; this clears the rx flag.
  - RX_LAT: capture uart_dout.
- Byte transmit sequence:
  - TX_POLL: poll status until bit0=0.
  - TX_WR: uart_cs=1, we=1, addr=00, uart_din=byte for exactly one cycle.
  - TX_GUARD: GUARD_CYCLES idle cycles. txbusy lags the write by 2 cycles and must not be polled before the guard expires.
- uart_cs is never high for more than one consecutive cycle.
- Command FSM: IDLE → CMD → AHI → ALO → LEN → body. The byte consumed at each step:
  - 0x57 'W': 2 address bytes, 1 length byte, then LEN data bytes. Each data byte produces one mem_we cycle at the current address; address increments after each byte. Reply 0x2E '.' after the last write.
  - 0x52 'R': 2 address bytes, 1 length byte. For each byte: mem_re for one cycle, capture mem_rdata the next cycle, transmit it, increment address. No trailing reply.
  - Any other command byte: err pulse, transmit 0x3F '?', return to IDLE. halt stays 0 for unknown commands.
- Arithmetic:
  - LEN=00 means 256 bytes. Use a 9-bit remaining-count.
  - Address is 16-bit and wraps FFFF→0000 with no error.
- Timeout:
  - The counter runs only while waiting for rx-ready in states AHI through the W data phase.
  - It clears on every received byte.
  - Reaching TIMEOUT_CYCLES-1 gives an err pulse, halt=0 and IDLE, with no reply. Memory bytes already written remain written.
- While in IDLE, the counter is held at 0.
- Memory writes complete in the same cycle as mem_we. There is no backpressure.
- halt rises the cycle after a valid W/R command byte is captured. It falls the cycle after the final TX_WR or the last mem write of a reply-less abort.

Test Plan:
- Serial model behind a real UART at 115200, rst pulsed low then high, then idle: all outputs hold their reset values and uart_cs stays 0.
- Send 57 02 00 02 AA 55 → mem_we at 0x0200=AA, then 0x0201=55; reply 2E; halt high from after 57 until the reply is written.
- Memory preloaded 0x0300..0x0302 = 11 22 33, send 52 03 00 03 → serial output 11 22 33 in order; three mem_re pulses at 0300, 0301, 0302.
- Send 57 FF FF 02 01 02 → writes FFFF=01 then 0000=02. Separately, 52 10 00 00 → exactly 256 bytes returned.
- Send 41 → err pulse, reply 3F, halt stays 0. Send 57 12 then stall longer than TIMEOUT_CYCLES (bench value 1000) → err pulse, no reply, IDLE; a following W command works normally.
- Assert rst low mid-way through a W data phase → outputs return to reset values at the next edge; no further mem_we, no reply; next command decodes correctly.

Source files
------------

// File: rtl/uart_loader.sv
// Serial monitor that drives an ACIA-style UART as host and loads or dumps system memory.
// Commands: 'W' ahi alo len data..., reply '.'; 'R' ahi alo len, streams memory bytes back.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter int unsigned GUARD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        uart_cs,
  output logic        uart_we,
  output logic [1:0]  uart_addr,
  output logic [7:0]  uart_din,
  input  logic [7:0]  uart_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        halt,
  output logic        err
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned GuardW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] ReplyOk  = 8'h2E;
  localparam logic [7:0] ReplyBad = 8'h3F;

  localparam logic [1:0] AddrData   = 2'b00;
  localparam logic [1:0] AddrStatus = 2'b01;

  typedef enum logic [3:0] {
    StIdle,
    StRxPoll,
    StRxPop,
    StRxLat,
    StMemWr,
    StMemRd,
    StMemCap,
    StTxPoll,
    StTxWr,
    StTxGuard
  } state_e;

  // Which byte of the command the byte-level sequencer is working on.
  typedef enum logic [2:0] {
    PhCmd,
    PhAhi,
    PhAlo,
    PhLen,
    PhWData,
    PhRData,
    PhReply
  } phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              armed_q, armed_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              poll_st;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      phase_q <= PhCmd;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      guard_q <= '0;
      tmo_q   <= '0;
      armed_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      guard_q <= guard_d;
      tmo_q   <= tmo_d;
      armed_q <= armed_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign poll_st = (state_q == StIdle) || (state_q == StRxPoll) || (state_q == StTxPoll);

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    guard_d = guard_q;
    tmo_d   = tmo_q;
    halt_d  = halt_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (armed_q && uart_dout[1]) begin
          state_d = StRxPop;
        end
      end
      StRxPoll: begin
        if (armed_q && uart_dout[1]) begin
          state_d = StRxPop;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          phase_d = PhCmd;
          halt_d  = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRxPop: state_d = StRxLat;
      StRxLat: begin
        byte_d  = uart_dout;
        tmo_d   = '0;
        state_d = StRxPoll;
        unique case (phase_q)
          PhCmd: begin
            if ((uart_dout == CmdWrite) || (uart_dout == CmdRead)) begin
              is_wr_d = (uart_dout == CmdWrite);
              halt_d  = 1'b1;
              phase_d = PhAhi;
            end else begin
              byte_d  = ReplyBad;
              err_d   = 1'b1;
              phase_d = PhReply;
              state_d = StTxPoll;
            end
          end
          PhAhi: begin
            addr_d[15:8] = uart_dout;
            phase_d      = PhAlo;
          end
          PhAlo: begin
            addr_d[7:0] = uart_dout;
            phase_d     = PhLen;
          end
          PhLen: begin
            // A length byte of zero stands for a full 256-byte block.
            cnt_d = (uart_dout == 8'h00) ? 9'd256 : {1'b0, uart_dout};
            if (is_wr_q) begin
              phase_d = PhWData;
            end else begin
              phase_d = PhRData;
              state_d = StMemRd;
            end
          end
          PhWData: state_d = StMemWr;
          default: begin
            state_d = StIdle;
            phase_d = PhCmd;
          end
        endcase
      end
      StMemWr: begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          byte_d  = ReplyOk;
          phase_d = PhReply;
          state_d = StTxPoll;
        end else begin
          state_d = StRxPoll;
        end
      end
      StMemRd: state_d = StMemCap;
      StMemCap: begin
        byte_d  = mem_rdata;
        addr_d  = addr_q + 16'd1;
        state_d = StTxPoll;
      end
      StTxPoll: begin
        if (armed_q && !uart_dout[0]) begin
          state_d = StTxWr;
        end
      end
      StTxWr: begin
        guard_d = GuardLast;
        state_d = StTxGuard;
        if ((phase_q == PhReply) || ((phase_q == PhRData) && (cnt_q == 9'd1))) begin
          halt_d = 1'b0;
        end
        if (phase_q == PhRData) begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      StTxGuard: begin
        // txbusy appears late after a write, so status is ignored until the guard expires.
        if (guard_q == '0) begin
          if ((phase_q == PhRData) && (cnt_q != 9'd0)) begin
            state_d = StMemRd;
          end else begin
            state_d = StIdle;
            phase_d = PhCmd;
          end
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = PhCmd;
      end
    endcase

    // Status data is registered: the first cycle of any poll still shows the previous address.
    armed_d = poll_st && (state_d == state_q);
  end

  // Outputs
  always_comb begin
    uart_cs   = 1'b0;
    uart_we   = 1'b0;
    uart_addr = AddrStatus;
    uart_din  = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    unique case (state_q)
      StRxPop: begin
        uart_cs   = 1'b1;
        uart_addr = AddrData;
      end
      StRxLat: uart_addr = AddrData;
      StTxWr: begin
        uart_cs   = 1'b1;
        uart_we   = 1'b1;
        uart_addr = AddrData;
        uart_din  = byte_q;
      end
      StMemWr: begin
        mem_we    = 1'b1;
        mem_wdata = byte_q;
      end
      StMemRd: mem_re = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign halt     = halt_q;
  assign err      = err_q;

endmodule
